uart_tx_scheduler: RTL

- Round-robin scheduler that shares one UART byte transmitter between NUM_REQ requesters.
- It sits between client logic (keypad/sensor/echo paths) and the transmitter.
- It grants one requester, captures its byte, issues a one-cycle start pulse, and holds the byte stable for the whole frame.
- It counts baud ticks to know when the frame (start, 8 data, stop) has finished, then enforces an idle guard before the next grant.

---
 rtl/uart_tx_scheduler_if.sv | 20 ++
 rtl/uart_tx_scheduler.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter handshake bundle for the UART TX scheduler.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0][7:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    tx_start;
    logic [7:0]              tx_data;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_start, tx_data
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART byte transmitter between NUM_REQ requesters,
// with frame timing from br_tick and an idle guard between frames.

module uart_tx_sched_lane #(
    parameter int PTR_W = 2,
    parameter int ID    = 0
) (
    input  logic             win_vld,
    input  logic [PTR_W-1:0] win_idx,
    input  logic [7:0]       data,
    output logic             grant,
    output logic [7:0]       data_sel
);
    assign grant    = win_vld && (win_idx == PTR_W'(ID));
    assign data_sel = grant ? data : 8'h00;
endmodule

module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int FRAME_TICKS = 10,
    parameter int GUARD_TICKS = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               br_tick,
    uart_tx_scheduler_if.slave bus,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic [CNT_W-1:0]   frame_cnt
);
    localparam int MAX_TICKS = (FRAME_TICKS > GUARD_TICKS) ? FRAME_TICKS : GUARD_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);
    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [TICK_W-1:0] FRAME_LAST = TICK_W'(FRAME_TICKS - 1);
    localparam logic [TICK_W-1:0] GUARD_LAST = TICK_W'((GUARD_TICKS > 0) ? GUARD_TICKS - 1 : 0);
    localparam logic [PTR_W:0]    NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, FRAME, GUARD} state_t;

    state_t                  state, state_n;
    logic [TICK_W-1:0]       tick_cnt, cnt_n;
    logic [PTR_W-1:0]        rr_ptr, ptr_n;
    logic [NUM_REQ-1:0]      ready_q, ready_n;
    logic                    start_q, start_n;
    logic [7:0]              data_q, data_n;
    logic [2:0]              gid_n;
    logic [CNT_W-1:0]        fcnt_n;
    logic                    busy_n;

    // Arbitration: rotate requests so rr_ptr sits at bit 0, take the lowest set bit.
    logic [NUM_REQ-1:0]      req_rot;
    logic [PTR_W-1:0]        win_off;
    logic [PTR_W:0]          win_sum;
    logic [PTR_W-1:0]        win_idx;
    logic                    win_vld;
    logic [NUM_REQ-1:0]      lane_grant;
    logic [NUM_REQ-1:0][7:0] lane_data;
    logic [7:0]              sel_data;

    assign req_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr);
    assign win_vld = |bus.req_valid;

    always_comb begin
        win_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) win_off = PTR_W'(k);
        end
    end

    assign win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    assign win_idx = (win_sum >= NUM_REQ_W) ? PTR_W'(win_sum - NUM_REQ_W) : win_sum[PTR_W-1:0];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        uart_tx_sched_lane #(.PTR_W(PTR_W), .ID(i)) u_lane (
            .win_vld  (win_vld),
            .win_idx  (win_idx),
            .data     (bus.req_data[i]),
            .grant    (lane_grant[i]),
            .data_sel (lane_data[i])
        );
    end

    always_comb begin
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) sel_data = sel_data | lane_data[i];
    end

    always_comb begin
        state_n = state;
        cnt_n   = tick_cnt;
        ptr_n   = rr_ptr;
        ready_n = '0;
        start_n = 1'b0;
        data_n  = data_q;
        gid_n   = grant_id;
        fcnt_n  = frame_cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    data_n  = sel_data;
                    gid_n   = 3'(win_idx);
                    ready_n = lane_grant;
                    ptr_n   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                // Transmitter is still idle here, so a tick in this cycle is dropped.
                start_n = 1'b1;
                state_n = FRAME;
            end
            FRAME: begin
                if (br_tick) begin
                    if (tick_cnt == FRAME_LAST) begin
                        fcnt_n  = frame_cnt + 1'b1;
                        state_n = (GUARD_TICKS > 0) ? GUARD : IDLE;
                    end else begin
                        cnt_n = tick_cnt + 1'b1;
                    end
                end
            end
            GUARD: begin
                if (br_tick) begin
                    if (tick_cnt == GUARD_LAST) state_n = IDLE;
                    else                        cnt_n   = tick_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // No tick carries across a state boundary.
        if (state_n != state) cnt_n = '0;
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            rr_ptr    <= '0;
            ready_q   <= '0;
            start_q   <= 1'b0;
            data_q    <= 8'h00;
            grant_id  <= 3'd0;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= cnt_n;
            rr_ptr    <= ptr_n;
            ready_q   <= ready_n;
            start_q   <= start_n;
            data_q    <= data_n;
            grant_id  <= gid_n;
            frame_cnt <= fcnt_n;
            busy      <= busy_n;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.tx_start  = start_q;
    assign bus.tx_data   = data_q;
endmodule
